// File: rtl/mem_port_arbiter_if.sv
// Requester + memory-bus bundle for mem_port_arbiter.
// The master modport belongs to the arbiter, which masters the memory bus; slave is the cpu/memory side.
interface mem_port_arbiter_if #(
   parameter int XLEN   = 64,
   parameter int IALIGN = 32
);
   logic              if_req;
   logic [XLEN-1:0]   if_addr;
   logic [IALIGN-1:0] if_rdata;
   logic              if_done;
   logic              if_err;
   logic              d_re;
   logic              d_we;
   logic [XLEN-1:0]   d_addr;
   logic [1:0]        d_size;
   logic [XLEN-1:0]   d_wdata;
   logic [XLEN-1:0]   d_rdata;
   logic              d_done;
   logic              d_err;
   logic              fence_sig;
   logic              fence_ack;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [7:0]        mem_be;
   logic              mem_re;
   logic              mem_we;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_ready;
   logic              busy;

   modport master (
      input  if_req, if_addr, d_re, d_we, d_addr, d_size, d_wdata, fence_sig,
             mem_rdata, mem_ready,
      output if_rdata, if_done, if_err, d_rdata, d_done, d_err, fence_ack,
             mem_addr, mem_wdata, mem_be, mem_re, mem_we, busy
   );

   modport slave (
      output if_req, if_addr, d_re, d_we, d_addr, d_size, d_wdata, fence_sig,
             mem_rdata, mem_ready,
      input  if_rdata, if_done, if_err, d_rdata, d_done, d_err, fence_ack,
             mem_addr, mem_wdata, mem_be, mem_re, mem_we, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; grant-to-done >= 2 cycles, one IDLE bubble between accesses.
// Strobes hold until mem_ready (or timeout abort); data may starve fetch for at most STARVE_LIMIT grants.
module mem_port_arbiter #(
   parameter int XLEN         = 64,
   parameter int IALIGN       = 32,
   parameter int TIMEOUT      = 255,
   parameter int STARVE_LIMIT = 2
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.master bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

   state_t        state;
   logic [7:0]    to_cnt;
   logic [SW-1:0] starve_cnt;
   logic          fence_pending;
   logic [2:0]    lane;
   logic          mis;

   logic          d_pend;
   logic          grant_d;
   logic [2:0]    d_lane;
   logic [7:0]    base_be;
   logic          d_mis;

   always_comb begin
      d_pend  = bus.d_re | bus.d_we;
      d_lane  = bus.d_addr[2:0];
      base_be = 8'h00;
      d_mis   = 1'b0;
      case (bus.d_size)
         2'd0: base_be = 8'h01;
         2'd1: begin base_be = 8'h03; d_mis = d_lane[0];      end
         2'd2: begin base_be = 8'h0F; d_mis = |d_lane[1:0];   end
         default: begin base_be = 8'hFF; d_mis = |d_lane;     end
      endcase
      grant_d = d_pend && (!bus.if_req || starve_cnt < SW'(STARVE_LIMIT));
   end

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         to_cnt        <= '0;
         starve_cnt    <= '0;
         fence_pending <= 1'b0;
         lane          <= '0;
         mis           <= 1'b0;
         bus.if_rdata  <= '0;
         bus.if_done   <= 1'b0;
         bus.if_err    <= 1'b0;
         bus.d_rdata   <= '0;
         bus.d_done    <= 1'b0;
         bus.d_err     <= 1'b0;
         bus.fence_ack <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
         bus.mem_re    <= 1'b0;
         bus.mem_we    <= 1'b0;
      end else begin
         bus.if_done   <= 1'b0;
         bus.if_err    <= 1'b0;
         bus.d_done    <= 1'b0;
         bus.d_err     <= 1'b0;
         bus.fence_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (fence_pending) begin
                  bus.fence_ack <= 1'b1;
                  fence_pending <= 1'b0;
               end else if (grant_d) begin
                  state         <= D_ACC;
                  starve_cnt    <= bus.if_req ? starve_cnt + 1'b1 : '0;
                  fence_pending <= bus.fence_sig;
                  to_cnt        <= '0;
                  lane          <= d_lane;
                  mis           <= d_mis;
                  bus.mem_addr  <= {bus.d_addr[XLEN-1:3], 3'b000};
                  // Misaligned accesses never touch the bus; D_ACC just reports the error.
                  bus.mem_be    <= d_mis ? 8'h00 : base_be << d_lane;
                  bus.mem_wdata <= bus.d_wdata << {d_lane, 3'b000};
                  bus.mem_we    <= !d_mis && bus.d_we;
                  bus.mem_re    <= !d_mis && !bus.d_we;
               end else if (bus.if_req) begin
                  state         <= IF_ACC;
                  starve_cnt    <= '0;
                  fence_pending <= bus.fence_sig;
                  to_cnt        <= '0;
                  lane          <= bus.if_addr[2:0];
                  mis           <= 1'b0;
                  bus.mem_addr  <= {bus.if_addr[XLEN-1:3], 3'b000};
                  bus.mem_be    <= bus.if_addr[2] ? 8'hF0 : 8'h0F;
                  bus.mem_wdata <= '0;
                  bus.mem_re    <= 1'b1;
                  bus.mem_we    <= 1'b0;
               end else if (bus.fence_sig) begin
                  bus.fence_ack <= 1'b1;
               end
            end
            default: begin
               if (bus.fence_sig) fence_pending <= 1'b1;
               if (mis) begin
                  bus.d_done <= 1'b1;
                  bus.d_err  <= 1'b1;
                  state      <= IDLE;
               end else if (bus.mem_ready) begin
                  bus.mem_re <= 1'b0;
                  bus.mem_we <= 1'b0;
                  state      <= IDLE;
                  if (state == IF_ACC) begin
                     bus.if_rdata <= IALIGN'(bus.mem_rdata >> {lane[2], 5'd0});
                     bus.if_done  <= 1'b1;
                  end else begin
                     if (bus.mem_re) bus.d_rdata <= bus.mem_rdata >> {lane, 3'b000};
                     bus.d_done <= 1'b1;
                  end
               end else if (to_cnt == 8'(TIMEOUT - 1)) begin
                  bus.mem_re <= 1'b0;
                  bus.mem_we <= 1'b0;
                  state      <= IDLE;
                  if (state == IF_ACC) begin
                     bus.if_rdata <= '0;
                     bus.if_done  <= 1'b1;
                     bus.if_err   <= 1'b1;
                  end else begin
                     bus.d_rdata <= '0;
                     bus.d_done  <= 1'b1;
                     bus.d_err   <= 1'b1;
                  end
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory/IO bus between cpu_main's instruction-fetch requester and its load/store requester.
- Sequences each access with a mem_ready handshake. Generates byte enables and lane alignment for sb/sh/sw/sd and lb..ld.
- Enforces fence ordering and a ready timeout.
- Sits between cpu_main and the memory/IO subsystem. Only one access is outstanding at a time.

Parameters:
- XLEN, 64, data/address width
- IALIGN, 32, instruction width returned to fetch
- TIMEOUT, 255, max cycles waiting for mem_ready before abort (8-bit counter)
- STARVE_LIMIT, 2, consecutive data grants allowed while fetch is waiting

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  XLEN  fetch address
- if_rdata  out  IALIGN  fetched instruction, valid with if_done
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  one-cycle pulse with if_done on timeout
- d_re  in  1  load request, level
- d_we  in  1  store request, level; d_re and d_we both high means store
- d_addr  in  XLEN  load/store address
- d_size  in  2  0=byte, 1=half, 2=word, 3=double
- d_wdata  in  XLEN  store data, LSB-justified
- d_rdata  out  XLEN  load data, right-shifted to LSB, not sign-extended
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  one-cycle pulse with d_done on misalignment or timeout
- fence_sig  in  1  fence request pulse
- fence_ack  out  1  one-cycle pulse when fence is satisfied
- mem_addr  out  XLEN  bus address, aligned down to 8 bytes
- mem_wdata  out  XLEN  lane-shifted store data
- mem_be  out  8  byte enables
- mem_re  out  1  read strobe, held until accepted
- mem_we  out  1  write strobe, held until accepted
- mem_rdata  in  XLEN  bus read data
- mem_ready  in  1  bus accepts/completes the access at this edge
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. Timeout counter, starvation counter and fence_pending cleared. An access in flight is dropped with no done pulse.
- States: IDLE, IF_ACC, D_ACC.
- IDLE arbitration, evaluated at each edge:
  - If fence_pending: grant nothing, pulse fence_ack, clear fence_pending.
  - Else if a data request is pending and (no fetch request or starve_cnt < STARVE_LIMIT): go to D_ACC. starve_cnt increments if if_req is high, else clears.
  - Else if if_req: go to IF_ACC, starve_cnt=0.
- On grant, register mem_addr = addr & ~7, plus mem_be, mem_wdata and strobes.
  - Fetch: mem_re=1, mem_be=0x0F or 0xF0 by addr[2].
- Data size/alignment:
  - Base mask by size: 0x01, 0x03, 0x0F, 0xFF, shifted left by addr[2:0].
  - mem_wdata = d_wdata << 8*addr[2:0].
  - Misaligned (half with addr[0]; word with addr[1:0]!=0; double with addr[2:0]!=0): no bus strobe. d_done and d_err pulse in the cycle after grant. Return to IDLE.
- In IF_ACC/D_ACC, strobes hold and the counter increments each cycle. At an edge with mem_ready=1:
  - Drop strobes.
  - Capture rdata: fetch = 32-bit lane selected by addr[2]; load = mem_rdata >> 8*addr[2:0].
  - Pulse done for one cycle, return to IDLE.
- Timeout: counter reaches TIMEOUT with no mem_ready. Drop strobes, pulse done+err, rdata=0, return to IDLE.
- Latency: request at edge k (IDLE) → strobe high after k. mem_ready at edge k+1 → done high for the cycle after k+1. Minimum 2 cycles.
- Back-to-back accesses have one IDLE bubble cycle.
- Requester dropping its request mid-access: the access still completes and done still pulses.
- fence_sig during an access: set fence_pending. The current access completes, then the IDLE cycle issues fence_ack with no grant that cycle.
- fence_sig in IDLE: fence_ack on the next cycle.
- fence_sig coincident with a request in IDLE: the request is granted first; the fence is acked after it completes.
- mem_ready while IDLE is ignored.

Test Plan:
- Store sd 0x0F0F07F00F0F07F0 at addr 0x0, mem_ready=1 → mem_we for exactly 1 cycle, mem_be=0xFF, mem_wdata=value; d_done 2 cycles after request.
- sb 0xAB to addr 0x5 → mem_addr=0x0, mem_be=0x20, mem_wdata[47:40]=0xAB; then sh to 0x3 → d_err+d_done, no mem_we.
- Load word from 0xC, mem_rdata=0x89ABCDEF_01234567 with ready delayed 3 cycles → mem_re held 4 cycles, d_rdata=0x0000_0000_89ABCDEF.
- if_req and d_re both held continuously → grant order D, D, IF, D, D, IF. Fetch at 0x4 returns mem_rdata[63:32].
- mem_ready stuck low on a fetch → strobe drops after 255 cycles, if_done+if_err pulse, busy falls.
- fence_sig during a load with 2-cycle ready, if_req pending → load done, then fence_ack, then the fetch is granted; async rst mid-access → mem_re=0 immediately, no done pulse.
